// File: rtl/sdp_wdma_wr_req_gen.sv
// sdp_wdma_wr_req_gen
//   Write-side DMA request generator for SDP. Walks the destination cube
//   (surfaces x lines x atoms), issuing one MCIF write command per burst
//   followed by that burst's data atoms, which pass straight through from
//   the datapath. The final burst asks for a write-complete ack; once it
//   arrives, dp2reg_done pulses for one cycle.
// Ports:
//   nvdla_core_clk / nvdla_core_rst : clock, synchronous active-high reset
//   reg2dp_*                        : layer configuration and enable
//   dp2wdma_valid/ready/pd          : datapath atom stream (64-bit atoms)
//   sdp2mcif_wr_req_valid/ready/pd  : MCIF write request (bit 65 = 1 for data)
//   mcif2sdp_wr_rsp_complete        : ack for the require_ack command
//   dp2reg_done, dp2reg_wdma_stall  : layer-done pulse, stall cycle counter
module sdp_wdma_wr_req_gen #(
  parameter int MAX_BURST = 8,
  parameter int AW        = 32
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rst,
  input  logic          reg2dp_op_en,
  input  logic [AW-1:0] reg2dp_dst_base_addr,
  input  logic [AW-1:0] reg2dp_dst_line_stride,
  input  logic [AW-1:0] reg2dp_dst_surface_stride,
  input  logic [12:0]   reg2dp_width,
  input  logic [12:0]   reg2dp_height,
  input  logic [12:0]   reg2dp_channel,
  input  logic          reg2dp_perf_dma_en,
  input  logic          dp2wdma_valid,
  output logic          dp2wdma_ready,
  input  logic [63:0]   dp2wdma_pd,
  output logic          sdp2mcif_wr_req_valid,
  input  logic          sdp2mcif_wr_req_ready,
  output logic [65:0]   sdp2mcif_wr_req_pd,
  input  logic          mcif2sdp_wr_rsp_complete,
  output logic          dp2reg_done,
  output logic [31:0]   dp2reg_wdma_stall
);

  typedef enum logic [2:0] {IDLE, CMD, DATA, WAIT_ACK, DONE} state_t;

  state_t        state_q, state_d;
  logic          op_en_q;
  logic [12:0]   w_q, h_q, s_q, beat_q;
  logic [12:0]   w_d, h_d, s_d, beat_d;
  logic [AW-1:0] addr_q, line_q, surf_q;
  logic [AW-1:0] addr_d, line_d, surf_d;
  logic [65:0]   cmd_q, cmd_d;
  logic [31:0]   stall_q;

  logic          start, data_fire, burst_end, last;
  logic [13:0]   rem;
  logic [12:0]   size, surf_last;
  logic [AW-1:0] base, lstride, sstride;

  assign base      = reg2dp_dst_base_addr      & ~AW'(7);
  assign lstride   = reg2dp_dst_line_stride    & ~AW'(7);
  assign sstride   = reg2dp_dst_surface_stride & ~AW'(7);
  assign surf_last = reg2dp_channel >> 3;

  assign start     = reg2dp_op_en & ~op_en_q;
  assign data_fire = (state_q == DATA) & dp2wdma_valid & sdp2mcif_wr_req_ready;
  assign burst_end = data_fire & (beat_q == cmd_q[44:32]);

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start) state_d = CMD;
      CMD:      if (sdp2mcif_wr_req_ready) state_d = DATA;
      DATA:     if (burst_end) state_d = cmd_q[45] ? WAIT_ACK : CMD;
      WAIT_ACK: if (mcif2sdp_wr_rsp_complete) state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // cube walk: running line/surface start addresses avoid multipliers
  always_comb begin
    w_d    = w_q;
    h_d    = h_q;
    s_d    = s_q;
    beat_d = beat_q;
    addr_d = addr_q;
    line_d = line_q;
    surf_d = surf_q;
    if (state_q == IDLE && start) begin
      w_d    = '0;
      h_d    = '0;
      s_d    = '0;
      beat_d = '0;
      addr_d = base;
      line_d = base;
      surf_d = base;
    end else if (data_fire) begin
      beat_d = burst_end ? 13'd0 : beat_q + 13'd1;
      if (w_q == reg2dp_width) begin
        w_d = '0;
        if (h_q == reg2dp_height) begin
          h_d    = '0;
          s_d    = s_q + 13'd1;
          surf_d = surf_q + sstride;
          line_d = surf_q + sstride;
          addr_d = surf_q + sstride;
        end else begin
          h_d    = h_q + 13'd1;
          line_d = line_q + lstride;
          addr_d = line_q + lstride;
        end
      end else begin
        w_d    = w_q + 13'd1;
        addr_d = addr_q + AW'(8);
      end
    end
  end

  // command for the burst starting at the next counter position; bursts
  // are clipped at the line end so they never straddle two lines
  always_comb begin
    rem   = {1'b0, reg2dp_width} + 14'd1 - {1'b0, w_d};
    size  = (rem > 14'(MAX_BURST)) ? 13'(MAX_BURST - 1) : 13'(rem - 14'd1);
    last  = (s_d == surf_last) && (h_d == reg2dp_height) && (rem <= 14'(MAX_BURST));
    cmd_d = {1'b0, 19'b0, last, size, 32'(addr_d)};
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      state_q <= IDLE;
      op_en_q <= 1'b0;
      w_q     <= '0;
      h_q     <= '0;
      s_q     <= '0;
      beat_q  <= '0;
      addr_q  <= '0;
      line_q  <= '0;
      surf_q  <= '0;
      cmd_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      op_en_q <= reg2dp_op_en;
      w_q     <= w_d;
      h_q     <= h_d;
      s_q     <= s_d;
      beat_q  <= beat_d;
      addr_q  <= addr_d;
      line_q  <= line_d;
      surf_q  <= surf_d;
      // command is captured on CMD entry and held until accepted
      if (state_d == CMD && state_q != CMD) cmd_q <= cmd_d;
      if (state_q == IDLE && start)
        stall_q <= '0;
      else if (reg2dp_perf_dma_en && (state_q == CMD || state_q == DATA) &&
               sdp2mcif_wr_req_valid && !sdp2mcif_wr_req_ready &&
               stall_q != 32'hFFFF_FFFF)
        stall_q <= stall_q + 32'd1;
    end
  end

  always_comb begin
    sdp2mcif_wr_req_valid = 1'b0;
    sdp2mcif_wr_req_pd    = '0;
    dp2wdma_ready         = 1'b0;
    case (state_q)
      CMD: begin
        sdp2mcif_wr_req_valid = 1'b1;
        sdp2mcif_wr_req_pd    = cmd_q;
      end
      DATA: begin
        sdp2mcif_wr_req_valid = dp2wdma_valid;
        sdp2mcif_wr_req_pd    = {1'b1, 1'b1, dp2wdma_pd};
        dp2wdma_ready         = sdp2mcif_wr_req_ready;
      end
      default: ;
    endcase
  end

  assign dp2reg_done       = (state_q == DONE);
  assign dp2reg_wdma_stall = stall_q;

endmodule
